// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: access sizes, FSM encoding,
// and the sub-word lane merge / load extract helpers that are also used by the LSU.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    // Natural alignment check; SIZE_X is never legal.
    function automatic logic access_ok(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~lo[0];
            SIZE_W:  ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo);
        logic [31:0] res;
        res = old_word;
        case (size)
            SIZE_B: begin
                case (lo)
                    2'b00:   res[7:0]   = wdata[7:0];
                    2'b01:   res[15:8]  = wdata[7:0];
                    2'b10:   res[23:16] = wdata[7:0];
                    default: res[31:24] = wdata[7:0];
                endcase
            end
            SIZE_H: begin
                if (lo[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0] = wdata[15:0];
                end
            end
            SIZE_W:  res = wdata;
            default: res = old_word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lo,
                                                 input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  res = {{24{sext & b[7]}}, b};
            SIZE_H:  res = {{16{sext & h[15]}}, h};
            SIZE_W:  res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Requester and memory-side signal bundle of the data-memory access controller.
interface dmem_access_ctrl_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we;
    logic [NREQ-1:0][1:0]  req_size;
    logic [NREQ-1:0]       req_signed;
    logic [NREQ-1:0][31:0] req_addr;
    logic [NREQ-1:0][31:0] req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic                  rsp_err;
    logic [31:0]           rsp_rdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last granted index, with wrap.
module dmem_access_ctrl_rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gidx_o,
    output logic            any_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx_s;

    // Search upward from the pointer for the first pending request.
    always_comb begin
        gnt_o  = '0;
        gidx_o = '0;
        any_o  = 1'b0;
        idx_s  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = PW'((int'(ptr_q) + k) % NREQ);
            if (!any_o && req_i[idx_s]) begin
                any_o         = 1'b1;
                gnt_o[idx_s]  = 1'b1;
                gidx_o        = idx_s;
            end else begin
                any_o = any_o;
            end
        end
    end

    // Pointer follows the last accepted grant.
    always_comb begin
        if (adv_i && any_o) begin
            ptr_d = gidx_o;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; reset value makes requester 0 the first winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates requesters onto a single-port word memory; sub-word loads are extracted and
// extended, sub-word stores are done as a two-cycle read-modify-write.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    dmem_access_ctrl_if.slave  bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_s;
    logic [PW-1:0]   gidx_s;
    logic            any_s;
    logic            accept_s;
    logic            ok_s;
    logic            sel_we_s;
    logic            sel_signed_s;
    logic [1:0]      sel_size_s;
    logic [31:0]     sel_addr_s;
    logic [31:0]     sel_wdata_s;
    logic [31:0]     word_addr_s;

    logic [31:0]     rmw_addr_q, rmw_addr_d;
    logic [31:0]     rmw_data_q, rmw_data_d;
    logic [NREQ-1:0] rmw_owner_q, rmw_owner_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;

    logic            mem_read_s;
    logic            mem_write_s;
    logic [31:0]     mem_addr_s;
    logic [31:0]     mem_wdata_s;

    dmem_access_ctrl_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (bus.req_valid),
        .adv_i  (accept_s),
        .gnt_o  (gnt_s),
        .gidx_o (gidx_s),
        .any_o  (any_s)
    );

    // Grants are only offered in IDLE and never while reset is held.
    assign accept_s     = any_s & (state_q == ST_IDLE) & ~rst;
    assign sel_we_s     = bus.req_we[gidx_s];
    assign sel_signed_s = bus.req_signed[gidx_s];
    assign sel_size_s   = bus.req_size[gidx_s];
    assign sel_addr_s   = bus.req_addr[gidx_s];
    assign sel_wdata_s  = bus.req_wdata[gidx_s];
    assign word_addr_s  = {sel_addr_s[31:2], 2'b00};
    assign ok_s         = access_ok(sel_size_s, sel_addr_s[1:0]);

    // Next state, memory drive and response capture.
    always_comb begin
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_data_d  = rmw_data_q;
        rmw_owner_d = rmw_owner_q;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = 32'h0000_0000;
        mem_wdata_s = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    rsp_valid_d = gnt_s;
                    if (!ok_s) begin
                        rsp_err_d = 1'b1;
                    end else if (!sel_we_s) begin
                        mem_read_s  = 1'b1;
                        mem_addr_s  = word_addr_s;
                        rsp_rdata_d = load_extract(bus.mem_rdata, sel_size_s,
                                                   sel_addr_s[1:0], sel_signed_s);
                    end else if (sel_size_s == SIZE_W) begin
                        mem_write_s = 1'b1;
                        mem_addr_s  = word_addr_s;
                        mem_wdata_s = sel_wdata_s;
                    end else begin
                        // Sub-word store: read now, write the merged word next cycle.
                        mem_read_s  = 1'b1;
                        mem_addr_s  = word_addr_s;
                        rsp_valid_d = '0;
                        rmw_addr_d  = word_addr_s;
                        rmw_data_d  = lane_merge(bus.mem_rdata, sel_wdata_s, sel_size_s,
                                                 sel_addr_s[1:0]);
                        rmw_owner_d = gnt_s;
                        state_d     = ST_RMW_WR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RMW_WR: begin
                mem_write_s = 1'b1;
                mem_addr_s  = rmw_addr_q;
                mem_wdata_s = rmw_data_q;
                rsp_valid_d = rmw_owner_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, RMW holding and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rmw_addr_q  <= 32'h0000_0000;
            rmw_data_q  <= 32'h0000_0000;
            rmw_owner_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_data_q  <= rmw_data_d;
            rmw_owner_q <= rmw_owner_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = accept_s ? gnt_s : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_read  = mem_read_s;
    assign bus.mem_write = mem_write_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed and randomized bench for dmem_access_ctrl against a transaction-level reference model.
module tb_dmem_access_ctrl;

    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_en = 1'b0;

    dmem_access_ctrl_if #(.NREQ(NREQ)) bus();

    dmem_access_ctrl #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    // Memory behind the DUT; sync_en copies the reference image in for preloading.
    always @(posedge clk) begin
        if (sync_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        logic [1:0]  v;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        exp_q[$];
    int          cyc = 0;
    int          ptr_m = NREQ - 1;
    bit          busy_m = 1'b0;
    logic [31:0] rmw_addr_m, rmw_data_m;
    int          rmw_own_m;
    int          last_grant = -1;

    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] lo, input logic sg);
        logic [31:0] x;
        x = word >> (int'(lo) * 8);
        if (sz == 2'd0) begin
            x = x & 32'h0000_00FF;
            if (sg && x[7]) x = x | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            x = x & 32'h0000_FFFF;
            if (sg && x[15]) x = x | 32'hFFFF_0000;
        end else begin
            x = word;
        end
        return x;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lo);
        logic [31:0] mask;
        mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (int'(lo) * 8);
        return (old & ~mask) | ((wd << (int'(lo) * 8)) & mask);
    endfunction

    // One cycle: inputs already driven; sample at the falling edge and step the model.
    task automatic check_cycle();
        rsp_t        r;
        int          g;
        logic [1:0]  sz;
        logic [31:0] a, w, wa;
        logic [1:0]  exp_rdy;
        @(negedge clk);
        cyc++;
        last_grant = -1;
        if (rst) begin
            exp_q.delete();
            busy_m = 1'b0;
            ptr_m  = NREQ - 1;
        end
        r.due = cyc; r.v = 2'b00; r.err = 1'b0; r.rdata = 32'h0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) r = exp_q.pop_front();
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(r.v));
        check_eq("rsp_err", 32'(bus.rsp_err), 32'(r.err));
        if (r.v != 2'b00 || rst) check_eq("rsp_rdata", bus.rsp_rdata, r.rdata);
        if (rst) begin
            check_eq("rst_ready", 32'(bus.req_ready), 32'h0);
            check_eq("rst_mem_write", 32'(bus.mem_write), 32'h0);
            check_eq("rst_mem_read", 32'(bus.mem_read), 32'h0);
        end else if (busy_m) begin
            check_eq("rmw_ready", 32'(bus.req_ready), 32'h0);
            check_eq("rmw_mem_write", 32'(bus.mem_write), 32'h1);
            check_eq("rmw_mem_read", 32'(bus.mem_read), 32'h0);
            check_eq("rmw_addr", bus.mem_addr, rmw_addr_m);
            check_eq("rmw_wdata", bus.mem_wdata, rmw_data_m);
            ref_mem[rmw_addr_m[7:2]] = rmw_data_m;
            exp_q.push_back('{cyc + 1, 2'(1 << rmw_own_m), 1'b0, 32'h0});
            busy_m = 1'b0;
        end else begin
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && bus.req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
            end
            exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
            if (g < 0) begin
                check_eq("idle_mem_read", 32'(bus.mem_read), 32'h0);
                check_eq("idle_mem_write", 32'(bus.mem_write), 32'h0);
            end else begin
                ptr_m = g;
                last_grant = g;
                sz = bus.req_size[g];
                a  = bus.req_addr[g];
                w  = bus.req_wdata[g];
                wa = {a[31:2], 2'b00};
                if (is_bad(sz, a)) begin
                    check_eq("err_mem_read", 32'(bus.mem_read), 32'h0);
                    check_eq("err_mem_write", 32'(bus.mem_write), 32'h0);
                    exp_q.push_back('{cyc + 1, exp_rdy, 1'b1, 32'h0});
                end else if (!bus.req_we[g]) begin
                    check_eq("ld_mem_read", 32'(bus.mem_read), 32'h1);
                    check_eq("ld_mem_write", 32'(bus.mem_write), 32'h0);
                    check_eq("ld_addr", bus.mem_addr, wa);
                    exp_q.push_back('{cyc + 1, exp_rdy, 1'b0,
                                      ref_load(ref_mem[a[7:2]], sz, a[1:0], bus.req_signed[g])});
                end else if (sz == 2'd2) begin
                    check_eq("sw_mem_write", 32'(bus.mem_write), 32'h1);
                    check_eq("sw_mem_read", 32'(bus.mem_read), 32'h0);
                    check_eq("sw_addr", bus.mem_addr, wa);
                    check_eq("sw_wdata", bus.mem_wdata, w);
                    ref_mem[a[7:2]] = w;
                    exp_q.push_back('{cyc + 1, exp_rdy, 1'b0, 32'h0});
                end else begin
                    check_eq("rmw_rd_mem_read", 32'(bus.mem_read), 32'h1);
                    check_eq("rmw_rd_mem_write", 32'(bus.mem_write), 32'h0);
                    check_eq("rmw_rd_addr", bus.mem_addr, wa);
                    busy_m     = 1'b1;
                    rmw_addr_m = wa;
                    rmw_data_m = ref_merge(ref_mem[a[7:2]], w, sz, a[1:0]);
                    rmw_own_m  = g;
                end
            end
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid[p]  = 1'b1;
        bus.req_we[p]     = we;
        bus.req_size[p]   = sz;
        bus.req_signed[p] = sg;
        bus.req_addr[p]   = a;
        bus.req_wdata[p]  = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.req_valid = '0;
            check_cycle();
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        bus.req_valid = '0;
        set_req(p, we, sz, sg, a, wd);
        check_cycle();
    endtask

    task automatic sync_mem();
        @(posedge clk); #1;
        bus.req_valid = '0;
        sync_en = 1'b1;
        check_cycle();
        @(posedge clk); #1;
        sync_en = 1'b0;
        check_cycle();
    endtask

    task automatic drive_random();
        int          r;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < NREQ; i++) begin
            if (!(bus.req_valid[i] && last_grant != i)) begin
                r  = int'($urandom_range(0, 9));
                sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                a  = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd1) a[0] = 1'b0;
                    if (sz == 2'd2) a[1:0] = 2'b00;
                end
                set_req(i, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
                bus.req_valid[i] = ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    initial begin
        bus.req_valid = '0; bus.req_we = '0; bus.req_size = '0; bus.req_signed = '0;
        bus.req_addr = '0;  bus.req_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom();
        sync_mem();
        idle(1);
        @(posedge clk); #1;
        rst = 1'b0;
        check_cycle();

        // 1: word load
        ref_mem[4] = 32'hDEAD_BEEF;
        sync_mem();
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        idle(1);
        check_eq("t1_lw_data", bus.rsp_rdata, 32'hDEAD_BEEF);

        // 2: signed byte and unsigned half loads
        ref_mem[4] = 32'h8011_2233;
        sync_mem();
        issue(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        idle(1);
        check_eq("t2_lb_data", bus.rsp_rdata, 32'hFFFF_FF80);
        issue(1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        idle(1);
        check_eq("t2_lhu_data", bus.rsp_rdata, 32'h0000_8011);

        // 3: byte store via RMW while both requesters wait
        ref_mem[8] = 32'h1122_3344;
        sync_mem();
        issue(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA);
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        set_req(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
        check_cycle();
        check_eq("t3_merge", bus.mem_wdata, 32'h1122_AA44);
        idle(3);
        check_eq("t3_mem", mem[8], 32'h1122_AA44);

        // 4: both requesters loading every cycle
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            for (int p = 0; p < NREQ; p++) begin
                if (last_grant == p || !bus.req_valid[p])
                    set_req(p, 1'b0, 2'd2, 1'b0, 32'($urandom_range(0, 63)) << 2, 32'h0);
            end
            check_cycle();
        end
        idle(2);

        // 5: misaligned and illegal requests
        issue(0, 1'b1, 2'd2, 1'b0, 32'h102, 32'h1234_5678);
        idle(1);
        check_eq("t5_sw_err", 32'(bus.rsp_err), 32'h1);
        issue(1, 1'b0, 2'd1, 1'b1, 32'h101, 32'h0);
        idle(1);
        check_eq("t5_lh_err", 32'(bus.rsp_err), 32'h1);
        issue(0, 1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
        idle(1);
        check_eq("t5_sz_err", 32'(bus.rsp_err), 32'h1);

        // 6: reset lands while the RMW write is pending
        ref_mem[12] = 32'h5566_7788;
        sync_mem();
        issue(0, 1'b1, 2'd1, 1'b0, 32'h30, 32'h0000_BEEF);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_valid = '0;
        check_cycle();
        idle(1);
        @(posedge clk); #1;
        rst = 1'b0;
        check_cycle();
        check_eq("t6_mem", mem[12], 32'h5566_7788);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            drive_random();
            check_cycle();
        end
        idle(3);
        for (int i = 0; i < 64; i++) check_eq("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
